// File: rtl/mpc_solver_sequencer.sv
// ---------------------------------------------------------------------------
// mpc_solver_sequencer
//
// Launches one solve of an HLS MPC solver core (ap_ctrl_hs handshake) for
// every accepted control-loop sample tick. It holds ap_start until the core
// accepts, waits for ap_done and then pulses result_latch to the actuation
// path. It also measures per-solve latency, tracks the worst case, counts
// ticks dropped while busy, and abandons a solve that exceeds TIMEOUT_CYCLES.
//
// Ports
//   clk_1, reset_n   : system clock, asynchronous active-low reset
//   ce_1             : clock enable; state changes only on enabled edges
//   enable           : 1 = accept new sample ticks
//   sample_tick      : one-ce-cycle sample-rate strobe
//   clear_stats      : synchronous clear of max_cycles/overrun_count/timeout_flag
//   ap_ready/ap_done : solver handshake inputs
//   ap_start         : solver start request (decoded from state)
//   result_latch     : one-ce-cycle pulse after a good completion
//   busy             : 1 in every state except IDLE
//   last_cycles      : latency of the last completed solve
//   max_cycles       : largest latency since reset/clear
//   overrun_count    : saturating count of ticks dropped while busy
//   timeout_flag     : sticky, a solve exceeded TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module mpc_solver_sequencer #(
    parameter int unsigned      CNT_W          = 16,
    parameter int unsigned      OVR_W          = 8,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic             clk_1,
    input  logic             reset_n,
    input  logic             ce_1,
    input  logic             enable,
    input  logic             sample_tick,
    input  logic             clear_stats,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_start,
    output logic             result_latch,
    output logic             busy,
    output logic [CNT_W-1:0] last_cycles,
    output logic [CNT_W-1:0] max_cycles,
    output logic [OVR_W-1:0] overrun_count,
    output logic             timeout_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cycles_q, last_cycles_d;
    logic [CNT_W-1:0] max_cycles_q, max_cycles_d;
    logic [OVR_W-1:0] overrun_count_q, overrun_count_d;
    logic             timeout_flag_q, timeout_flag_d;
    logic             result_latch_q, result_latch_d;

    logic             done_evt;
    logic             timeout_evt;
    logic             overrun_evt;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case/if tree leaves it unassigned (which would infer a latch).
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_cycles_d   = last_cycles_q;
        max_cycles_d    = max_cycles_q;
        overrun_count_d = overrun_count_q;
        timeout_flag_d  = timeout_flag_q;
        result_latch_d  = 1'b0;
        done_evt        = 1'b0;
        timeout_evt     = 1'b0;

        // Saturating increment; the timeout bound keeps it from ever wrapping,
        // but saturation keeps the counter safe if the bound is misconfigured.
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (sample_tick && enable) begin
                    state_d = S_START;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_START: begin
                // Ready and done together is a completed solve that never
                // visits WAIT_DONE.
                if (ap_ready && ap_done) begin
                    done_evt = 1'b1;
                end else if (cnt_q == TIMEOUT_CYCLES) begin
                    timeout_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (ap_ready) begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (ap_done) begin
                    done_evt = 1'b1;
                end else if (cnt_q == TIMEOUT_CYCLES) begin
                    timeout_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DRAIN: begin
                // Late completion of an abandoned solve: return without
                // result_latch so the stale result never reaches actuation.
                if (ap_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Latency statistics; a completion in the clear cycle restarts the
        // worst case from this solve instead of zero.
        if (done_evt) begin
            state_d        = S_IDLE;
            result_latch_d = 1'b1;
            last_cycles_d  = cnt_q;
            if (clear_stats || (cnt_q > max_cycles_q)) begin
                max_cycles_d = cnt_q;
            end
        end else if (clear_stats) begin
            max_cycles_d = '0;
        end

        if (timeout_evt) begin
            state_d        = S_DRAIN;
            timeout_flag_d = 1'b1;
        end else if (clear_stats) begin
            timeout_flag_d = 1'b0;
        end

        // Any tick outside IDLE is dropped, including the tick that lands on
        // the cycle returning to IDLE, and is counted regardless of enable.
        overrun_evt = sample_tick && (state_q != S_IDLE);
        if (clear_stats) begin
            overrun_count_d = overrun_evt ? OVR_W'(1) : '0;
        end else if (overrun_evt && (overrun_count_q != '1)) begin
            overrun_count_d = overrun_count_q + OVR_W'(1);
        end
    end

    always_ff @(posedge clk_1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            last_cycles_q   <= '0;
            max_cycles_q    <= '0;
            overrun_count_q <= '0;
            timeout_flag_q  <= 1'b0;
            result_latch_q  <= 1'b0;
        end else if (ce_1) begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            last_cycles_q   <= last_cycles_d;
            max_cycles_q    <= max_cycles_d;
            overrun_count_q <= overrun_count_d;
            timeout_flag_q  <= timeout_flag_d;
            result_latch_q  <= result_latch_d;
        end
    end

    // ap_start and busy decode straight from state so a reset drops them
    // immediately and the core sees the request in the first START cycle.
    assign ap_start      = (state_q == S_START);
    assign busy          = (state_q != S_IDLE);
    assign result_latch  = result_latch_q;
    assign last_cycles   = last_cycles_q;
    assign max_cycles    = max_cycles_q;
    assign overrun_count = overrun_count_q;
    assign timeout_flag  = timeout_flag_q;

endmodule

// File: tb/tb_mpc_solver_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mpc_solver_sequencer
//
// Directed and randomized solves against a small statistics model: each solve
// is described by the cycle the core accepts (r) and the cycle it finishes
// (d), so the expected latency is simply d and ap_start is high for r cycles.
// ---------------------------------------------------------------------------
module tb_mpc_solver_sequencer;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned OVR_W = 8;
    localparam int          TMO   = 20;
    localparam int          OVR_MAX = (1 << OVR_W) - 1;

    logic             clk_1 = 1'b0;
    logic             reset_n;
    logic             ce_1;
    logic             enable;
    logic             sample_tick;
    logic             clear_stats;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_start;
    logic             result_latch;
    logic             busy;
    logic [CNT_W-1:0] last_cycles;
    logic [CNT_W-1:0] max_cycles;
    logic [OVR_W-1:0] overrun_count;
    logic             timeout_flag;

    int vectors     = 0;
    int miscompares = 0;

    // Reference statistics, updated from the rules of each solve outcome.
    int model_last = 0;
    int model_max  = 0;
    int model_ovr  = 0;
    int model_to   = 0;

    mpc_solver_sequencer #(
        .CNT_W          (CNT_W),
        .OVR_W          (OVR_W),
        .TIMEOUT_CYCLES (16'd20)
    ) dut (
        .clk_1         (clk_1),
        .reset_n       (reset_n),
        .ce_1          (ce_1),
        .enable        (enable),
        .sample_tick   (sample_tick),
        .clear_stats   (clear_stats),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_start      (ap_start),
        .result_latch  (result_latch),
        .busy          (busy),
        .last_cycles   (last_cycles),
        .max_cycles    (max_cycles),
        .overrun_count (overrun_count),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_1);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".last"}, 32'(last_cycles), model_last);
        check({tag, ".max"},  32'(max_cycles), model_max);
        check({tag, ".ovr"},  32'(overrun_count), model_ovr);
        check({tag, ".to"},   32'(timeout_flag), model_to);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= OVR_MAX) ? OVR_MAX : v + 1;
    endfunction

    // One complete solve: ready in cycle r, done in cycle d (1 <= r <= d <= TMO).
    task automatic do_solve(input string tag, input int r, input int d, input bit rnd_ticks);
        int starts;
        starts      = 0;
        enable      = 1'b1;
        sample_tick = 1'b1;
        step();
        for (int k = 1; k <= d; k++) begin
            if (ap_start === 1'b1) starts++;
            ap_ready    = (k == r);
            ap_done     = (k == d);
            sample_tick = rnd_ticks && ($urandom_range(3, 0) == 0);
            if (sample_tick) model_ovr = sat_inc(model_ovr);
            step();
        end
        ap_ready    = 1'b0;
        ap_done     = 1'b0;
        sample_tick = 1'b0;
        model_last  = d;
        if (d > model_max) model_max = d;
        check({tag, ".starts"}, starts, r);
        check({tag, ".latch"}, 32'(result_latch), 1);
        check({tag, ".busy"}, 32'(busy), 0);
        check_stats(tag);
        step();
        check({tag, ".latch_end"}, 32'(result_latch), 0);
    endtask

    initial begin
        int d;
        int r;
        int gap;

        reset_n     = 1'b0;
        ce_1        = 1'b1;
        enable      = 1'b0;
        sample_tick = 1'b0;
        clear_stats = 1'b0;
        ap_ready    = 1'b0;
        ap_done     = 1'b0;
        #12;
        check("rst.ap_start", 32'(ap_start), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.latch", 32'(result_latch), 0);
        check_stats("rst");
        @(negedge clk_1);
        reset_n = 1'b1;
        step();

        // Ready in the first START cycle, done four cycles later.
        do_solve("basic", 1, 5, 1'b0);

        // Worst-case tracking and clear_stats.
        do_solve("lat12", 3, 12, 1'b0);
        do_solve("lat7", 2, 7, 1'b0);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        model_max = 0;
        model_ovr = 0;
        model_to  = 0;
        check_stats("clear");
        do_solve("lat9", 5, 9, 1'b0);

        // Delayed accept with ready and done together.
        do_solve("rdy_done", 4, 4, 1'b0);

        // Clock enable gaps between enabled cycles: only ce cycles count.
        enable      = 1'b1;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        ap_ready    = 1'b1;
        step();
        ap_ready    = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            ce_1 = 1'b0;
            step();
            ce_1    = 1'b1;
            ap_done = (k == 5);
            step();
            ap_done = 1'b0;
        end
        model_last = 5;
        if (model_last > model_max) model_max = model_last;
        check("ce.latch", 32'(result_latch), 1);
        check_stats("ce");
        ce_1 = 1'b0;
        step();
        check("ce.latch_hold", 32'(result_latch), 1);
        ce_1 = 1'b1;
        step();
        check("ce.latch_end", 32'(result_latch), 0);

        // Randomized solves with ticks while busy and ignored idle ticks.
        for (int n = 0; n < 20; n++) begin
            gap = $urandom_range(3, 0);
            enable = 1'b0;
            for (int g = 0; g < gap; g++) begin
                sample_tick = 1'($urandom_range(1, 0));
                step();
            end
            sample_tick = 1'b0;
            check("rnd.idle", 32'(busy), 0);
            d = $urandom_range(TMO, 1);
            r = $urandom_range(d, 1);
            do_solve("rnd", r, d, 1'b1);
        end

        // Completion exactly at the timeout bound is still a good solve.
        do_solve("edge20", 1, TMO, 1'b0);

        // Hung solve: timeout, drain, overrun saturation, clear with tick.
        enable      = 1'b1;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            ap_ready = (k == 1);
            step();
            if (k == TMO - 1) check("tmo.before", 32'(timeout_flag), 0);
        end
        ap_ready = 1'b0;
        model_to = 1;
        check("tmo.busy", 32'(busy), 1);
        check("tmo.latch", 32'(result_latch), 0);
        check_stats("tmo");
        sample_tick = 1'b1;
        for (int k = 0; k < 300; k++) begin
            model_ovr = sat_inc(model_ovr);
            step();
        end
        check("ovr.sat", 32'(overrun_count), OVR_MAX);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        sample_tick = 1'b0;
        model_ovr = 1;
        model_max = 0;
        model_to  = 0;
        check_stats("ovr.clear");
        step();
        check("drain.busy", 32'(busy), 1);
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        check("drain.busy_end", 32'(busy), 0);
        check("drain.latch", 32'(result_latch), 0);
        check_stats("drain");
        do_solve("post_drain", 2, 3, 1'b0);

        // Asynchronous reset in the middle of WAIT_DONE.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        model_last = 0;
        model_max  = 0;
        model_ovr  = 0;
        model_to   = 0;
        check("arst.ap_start", 32'(ap_start), 0);
        check("arst.busy", 32'(busy), 0);
        check("arst.latch", 32'(result_latch), 0);
        check_stats("arst");
        @(negedge clk_1);
        reset_n = 1'b1;
        step();
        do_solve("after_rst", 2, 6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mpc_solver_sequencer.md
Name: mpc_solver_sequencer

Overview:
- Sequences the HLS-generated MPC solver core (ap_ctrl_hs handshake) from the control-loop sample strobe.
- On each sample tick it:
  - launches one solve;
  - holds ap_start until the core accepts;
  - waits for completion and emits a result-latch strobe to the actuation path.
- Also measures per-solve latency, tracks the worst case, counts overruns (tick while busy) and aborts supervision on timeout.
- Sits between the sample-rate generator and the solver in the motor control loop.

Parameters:
CNT_W, 16, width of cycle counters (latency, max latency).
OVR_W, 8, width of overrun counter.
TIMEOUT_CYCLES, 16'd50000, ce-qualified cycles after launch before a solve is declared hung; must be >= 2 and < 2^CNT_W.

Ports:
clk_1  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
ce_1  in  1  clock enable; all state updates occur only on clk_1 edges with ce_1=1.
enable  in  1  1 = accept sample ticks; 0 = ignore new ticks (a running solve still completes).
sample_tick  in  1  one-ce-cycle strobe at control sample rate.
clear_stats  in  1  synchronous clear of max_cycles, overrun_count, timeout_flag.
ap_ready  in  1  solver accepted inputs.
ap_done  in  1  solver result valid (one cycle).
ap_start  out  1  solver start request.
result_latch  out  1  one-cycle pulse, cycle after ap_done seen in WAIT_DONE.
busy  out  1  1 in any state except IDLE.
last_cycles  out  CNT_W  latency of last completed solve.
max_cycles  out  CNT_W  largest last_cycles since reset/clear.
overrun_count  out  OVR_W  saturating count of dropped ticks.
timeout_flag  out  1  sticky: a solve exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; every output 0; internal counter 0.
- ce_1=0: state, counters and registered outputs hold. result_latch is a registered pulse and lasts exactly one ce cycle.
- FSM states: IDLE, START, WAIT_DONE, DRAIN.
- IDLE:
  - sample_tick & enable -> START; cnt<=1.
  - Otherwise stay.
  - ap_start=0.
- START:
  - ap_start=1 (combinational from state).
  - cnt increments each ce cycle.
  - ap_ready & ap_done same cycle -> treat as completion (see WAIT_DONE done action), go IDLE.
  - ap_ready only -> WAIT_DONE.
- WAIT_DONE:
  - ap_start=0.
  - On ap_done:
    - last_cycles<=cnt; max_cycles<=max(max_cycles,cnt); result_latch<=1 next cycle; -> IDLE.
    - If clear_stats is asserted in the same cycle, max_cycles<=cnt.
  - Otherwise cnt++.
- Timeout: in START or WAIT_DONE, if cnt==TIMEOUT_CYCLES and no ap_done this cycle:
  - timeout_flag<=1; -> DRAIN.
  - last_cycles and max_cycles are not updated.
- DRAIN:
  - ap_start=0.
  - Wait for ap_done, then go IDLE with no result_latch, so stale results are not applied.
  - Only reset_n exits DRAIN if the core never finishes.
- Latency definition: cnt=1 in first START cycle; reported value = ce cycles from first ap_start cycle through the ap_done cycle inclusive. Example: ready in cycle 1, done in cycle 5 -> 5.
- Counter saturates at all-ones; cannot wrap because TIMEOUT_CYCLES < 2^CNT_W.
- Overrun:
  - sample_tick while busy=1 (START, WAIT_DONE, DRAIN) -> overrun_count++, saturating at 2^OVR_W-1; the tick is dropped.
  - A tick in the same cycle as the IDLE-return transition counts as overrun.
  - Ticks with enable=0 in IDLE are ignored and not counted.
- clear_stats:
  - Zeroes max_cycles, overrun_count and timeout_flag.
  - An event in the same cycle wins, e.g. overrun_count<=1 if tick-while-busy coincides.
  - last_cycles is unaffected.
- enable deasserted mid-solve: no effect on the current solve.
- reset_n asserted mid-solve: immediate IDLE, ap_start=0; the solver must be reset by the same reset.

Test Plan:
- Reset release, ce_1=1, tick; model asserts ready in 1st START cycle and done 4 cycles later -> ap_start high exactly 1 cycle, last_cycles=5, max_cycles=5, result_latch one pulse, busy back to 0.
- Two solves with latencies 12 then 7, then clear_stats, then latency 9 -> max_cycles 12, 12, 0, 9; last_cycles 12, 7, 7, 9.
- Model delays ap_ready 3 cycles, then asserts ready and done together -> ap_start high 4 cycles, last_cycles=4, returns IDLE directly.
- TIMEOUT_CYCLES=20, model never asserts done -> timeout_flag=1 at cnt 20, no result_latch, state DRAIN; late ap_done -> IDLE; next tick launches normally.
- 300 ticks while busy with OVR_W=8 -> overrun_count saturates at 255; tick coincident with clear_stats -> 1.
- ce_1 toggled 1,0,1,0 during a solve -> latency counts only ce cycles; reset_n pulsed mid-WAIT_DONE -> all outputs 0 asynchronously, IDLE.
